// File: rtl/mnist_pixel_framer.sv
// Frames an upstream byte stream into one IMG_W x IMG_H image per start pulse,
// tagging each pixel with row/column and marking the final pixel of the frame.
module mnist_pixel_framer #(
  parameter int          IMG_W    = 28,
  parameter int          IMG_H    = 28,
  parameter int          BINARIZE = 0,
  parameter logic [7:0]  THRESH   = 8'd128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] pix_data,
  output logic       pix_wr_en,
  output logic [4:0] pix_row,
  output logic [4:0] pix_col,
  output logic       pix_last,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  localparam logic [4:0] COL_MAX = 5'(IMG_W - 1);
  localparam logic [4:0] ROW_MAX = 5'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [4:0] row, col;
  logic       xfer, at_row_end, at_last;
  logic [7:0] pix_in;

  // abort squashes a same-cycle handshake so no partial-frame pixel escapes
  assign xfer       = s_ready && s_valid && !abort;
  assign at_row_end = (col == COL_MAX);
  assign at_last    = at_row_end && (row == ROW_MAX);

  if (BINARIZE != 0) begin : g_bin
    assign pix_in = (s_data >= THRESH) ? 8'hFF : 8'h00;
  end else begin : g_raw
    assign pix_in = s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (xfer && at_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    case (state)
      RUN:     begin s_ready = 1'b1; busy = 1'b1; end
      DONE:    busy = 1'b1;
      default: ;
    endcase
  end

  // Counters sit at zero whenever no frame is in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (abort || (state == IDLE && start)) begin
      row <= '0;
      col <= '0;
    end else if (xfer) begin
      if (at_row_end) begin
        col <= '0;
        row <= at_last ? 5'd0 : row + 5'd1;
      end else begin
        col <= col + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_data  <= '0;
      pix_row   <= '0;
      pix_col   <= '0;
      pix_wr_en <= 1'b0;
      pix_last  <= 1'b0;
    end else begin
      pix_wr_en <= xfer;
      pix_last  <= xfer && at_last;
      if (xfer) begin
        pix_data <= pix_in;
        pix_row  <= row;
        pix_col  <= col;
      end
    end
  end

  // Completion is reported on leaving DONE, one cycle after pix_last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= (state == DONE) && !abort;
      if (state == DONE && !abort) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule
